// File: rtl/ibex_wb_arbiter.sv
// Writeback arbiter for the register file write port: EX results win, and colliding load data
// waits in a small FIFO. Also tracks a per-register busy scoreboard for outstanding loads.
module ibex_wb_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned BufDepth  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ex_valid_i,
    input  logic [AddrWidth-1:0]    ex_waddr_i,
    input  logic [DataWidth-1:0]    ex_wdata_i,
    input  logic                    lsu_issue_i,
    input  logic [AddrWidth-1:0]    lsu_issue_waddr_i,
    input  logic                    lsu_rvalid_i,
    output logic                    lsu_rready_o,
    input  logic [AddrWidth-1:0]    lsu_waddr_i,
    input  logic [DataWidth-1:0]    lsu_wdata_i,
    output logic                    rf_we_o,
    output logic [AddrWidth-1:0]    rf_waddr_o,
    output logic [DataWidth-1:0]    rf_wdata_o,
    output logic [2**AddrWidth-1:0] busy_o,
    output logic                    buf_empty_o
);

    localparam int unsigned NumRegs  = 2**AddrWidth;
    localparam int unsigned PtrWidth = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned CntWidth = $clog2(BufDepth + 1);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(BufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [AddrWidth-1:0] buf_addr_q [BufDepth];
    logic [DataWidth-1:0] buf_data_q [BufDepth];
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;

    logic                 rf_we_q, rf_we_d;
    logic [AddrWidth-1:0] rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
    logic                 rf_load_q, rf_load_d;
    logic [NumRegs-1:0]   busy_q, busy_d;

    logic ex_req;
    logic lsu_acc;
    logic lsu_keep;
    logic push;
    logic pop;

    assign lsu_rready_o = (count_q < CntWidth'(BufDepth));
    assign buf_empty_o  = (count_q == '0);
    assign ex_req       = ex_valid_i && (ex_waddr_i != '0);
    assign lsu_acc      = lsu_rvalid_i && lsu_rready_o;
    // Loads to x0 are consumed here and go no further.
    assign lsu_keep     = lsu_acc && (lsu_waddr_i != '0);

    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        rf_we_d    = 1'b0;
        rf_load_d  = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (ex_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ex_waddr_i;
            rf_wdata_d = ex_wdata_i;
            push       = lsu_keep;
        end else if (!buf_empty_o) begin
            pop        = 1'b1;
            push       = lsu_keep;
            rf_we_d    = 1'b1;
            rf_load_d  = 1'b1;
            rf_waddr_d = buf_addr_q[rd_ptr_q];
            rf_wdata_d = buf_data_q[rd_ptr_q];
        end else if (lsu_keep) begin
            rf_we_d    = 1'b1;
            rf_load_d  = 1'b1;
            rf_waddr_d = lsu_waddr_i;
            rf_wdata_d = lsu_wdata_i;
        end
    end

    always_comb begin
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CntWidth'(push) - CntWidth'(pop);
    end

    // Clear on commit is applied first so a same-cycle reissue keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q && rf_load_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (lsu_issue_i) begin
            busy_d[lsu_issue_waddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= lsu_waddr_i;
            buf_data_q[wr_ptr_q] <= lsu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_load_q  <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_load_q  <= rf_load_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Directed bench for ibex_wb_arbiter: a queue-based model checked every cycle, plus literal
// expectations for each scenario.
module tb_ibex_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic [AW-1:0] ex_waddr = '0;
    logic [DW-1:0] ex_wdata = '0;
    logic          lsu_issue = 1'b0;
    logic [AW-1:0] lsu_issue_waddr = '0;
    logic          lsu_rvalid = 1'b0;
    logic          lsu_rready;
    logic [AW-1:0] lsu_waddr = '0;
    logic [DW-1:0] lsu_wdata = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   busy;
    logic          buf_empty;

    int tests = 0;
    int fails = 0;

    ibex_wb_arbiter #(.DataWidth(DW), .AddrWidth(AW), .BufDepth(DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ex_valid_i       (ex_valid),
        .ex_waddr_i       (ex_waddr),
        .ex_wdata_i       (ex_wdata),
        .lsu_issue_i      (lsu_issue),
        .lsu_issue_waddr_i(lsu_issue_waddr),
        .lsu_rvalid_i     (lsu_rvalid),
        .lsu_rready_o     (lsu_rready),
        .lsu_waddr_i      (lsu_waddr),
        .lsu_wdata_i      (lsu_wdata),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .rf_wdata_o       (rf_wdata),
        .busy_o           (busy),
        .buf_empty_o      (buf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: loads awaiting writeback in acceptance order, including any taken this cycle.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          pend[$];
    logic          m_we;
    logic          m_load;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [31:0]   m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_we = 1'b0;
            m_load = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_busy = '0;
        end else begin
            bit acc;
            ent_t e;
            acc = lsu_rvalid && (pend.size() < DEPTH);
            if (m_we && m_load) m_busy[m_waddr] = 1'b0;
            if (lsu_issue && lsu_issue_waddr != 0) m_busy[lsu_issue_waddr] = 1'b1;
            if (acc && lsu_waddr != 0) pend.push_back('{a: lsu_waddr, d: lsu_wdata});
            if (ex_valid && ex_waddr != 0) begin
                m_we = 1'b1;
                m_load = 1'b0;
                m_waddr = ex_waddr;
                m_wdata = ex_wdata;
            end else if (pend.size() != 0) begin
                e = pend.pop_front();
                m_we = 1'b1;
                m_load = 1'b1;
                m_waddr = e.a;
                m_wdata = e.d;
            end else begin
                m_we = 1'b0;
                m_load = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model rf_we", 64'(rf_we), 64'(m_we));
        chk("model rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("model rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("model busy", 64'(busy), 64'(m_busy));
        chk("model rready", 64'(lsu_rready), 64'(pend.size() < DEPTH));
        chk("model buf_empty", 64'(buf_empty), 64'(pend.size() == 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        lsu_issue = 1'b1;
        lsu_issue_waddr = a;
        tick();
        lsu_issue = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] got[$];
        bit acc;

        tick();
        tick();
        chk("reset rf_we", 64'(rf_we), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset rready", 64'(lsu_rready), 1);
        chk("reset buf_empty", 64'(buf_empty), 1);
        rst = 1'b0;
        tick();

        // EX-only, then EX to x0 is dropped while the address/data hold.
        ex_valid = 1'b1; ex_waddr = 5; ex_wdata = 32'hDEADBEEF;
        tick();
        chk("ex we", 64'(rf_we), 1);
        chk("ex waddr", 64'(rf_waddr), 5);
        chk("ex wdata", 64'(rf_wdata), 64'hDEADBEEF);
        ex_waddr = 0; ex_wdata = 32'h1;
        tick();
        chk("ex x0 we", 64'(rf_we), 0);
        chk("ex x0 hold addr", 64'(rf_waddr), 5);
        ex_valid = 1'b0;

        // Collision: EX wins, load follows a cycle later, busy falls after commit.
        issue(7);
        chk("issue x7 busy", 64'(busy), 64'h80);
        ex_valid = 1'b1; ex_waddr = 3; ex_wdata = 32'h11;
        lsu_rvalid = 1'b1; lsu_waddr = 7; lsu_wdata = 32'h22;
        tick();
        ex_valid = 1'b0; lsu_rvalid = 1'b0;
        chk("coll N+1 waddr", 64'(rf_waddr), 3);
        chk("coll N+1 wdata", 64'(rf_wdata), 64'h11);
        chk("coll N+1 buffered", 64'(buf_empty), 0);
        tick();
        chk("coll N+2 we", 64'(rf_we), 1);
        chk("coll N+2 waddr", 64'(rf_waddr), 7);
        chk("coll N+2 wdata", 64'(rf_wdata), 64'h22);
        chk("coll N+2 busy", 64'(busy), 64'h80);
        tick();
        chk("coll N+3 busy", 64'(busy), 0);

        // Bypass with empty FIFO.
        issue(9);
        lsu_rvalid = 1'b1; lsu_waddr = 9; lsu_wdata = 32'h1234;
        tick();
        lsu_rvalid = 1'b0;
        chk("bypass waddr", 64'(rf_waddr), 9);
        chk("bypass wdata", 64'(rf_wdata), 64'h1234);
        chk("bypass busy N+1", 64'(busy), 64'h200);
        tick();
        chk("bypass busy N+2", 64'(busy), 0);

        // Back-pressure under continuous EX traffic.
        issue(10); issue(11); issue(12);
        ex_valid = 1'b1; ex_waddr = 1; ex_wdata = 32'h100;
        lsu_rvalid = 1'b1; lsu_waddr = 10; lsu_wdata = 32'hA0;
        tick();
        ex_wdata = 32'h101; lsu_waddr = 11; lsu_wdata = 32'hA1;
        tick();
        ex_wdata = 32'h102; lsu_waddr = 12; lsu_wdata = 32'hA2;
        chk("bp rready low", 64'(lsu_rready), 0);
        tick();
        ex_wdata = 32'h103;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            acc = lsu_rvalid && lsu_rready;
            tick();
            if (acc) lsu_rvalid = 1'b0;
            if (rf_we && rf_waddr >= 10 && rf_waddr <= 12) got.push_back(rf_waddr);
        end
        chk("bp load writes", 64'(got.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp order", (i < got.size()) ? 64'(got[i]) : 64'hFF, 64'(10 + i));
        end
        chk("bp rready back", 64'(lsu_rready), 1);
        chk("bp drained", 64'(buf_empty), 1);
        chk("bp busy clear", 64'(busy), 0);
        lsu_rvalid = 1'b0;

        // Scoreboard race: reissue on the commit cycle keeps the bit; x0 issue ignored.
        issue(4);
        lsu_rvalid = 1'b1; lsu_waddr = 4; lsu_wdata = 32'h44;
        tick();
        lsu_rvalid = 1'b0;
        chk("race commit waddr", 64'(rf_waddr), 4);
        issue(4);
        chk("race busy kept", 64'(busy), 64'h10);
        issue(0);
        chk("issue x0 busy", 64'(busy), 64'h10);

        // Fill the FIFO then reset asynchronously mid-cycle.
        ex_valid = 1'b1; ex_waddr = 1; ex_wdata = 32'h200;
        lsu_rvalid = 1'b1; lsu_waddr = 13; lsu_wdata = 32'hD0;
        tick();
        lsu_waddr = 14; lsu_wdata = 32'hD1;
        tick();
        lsu_rvalid = 1'b0;
        chk("pre-rst full", 64'(lsu_rready), 0);
        chk("pre-rst busy", 64'(busy), 64'h10);
        #2;
        rst = 1'b1;
        ex_valid = 1'b0;
        #1;
        chk("rst we", 64'(rf_we), 0);
        chk("rst waddr", 64'(rf_waddr), 0);
        chk("rst wdata", 64'(rf_wdata), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst rready", 64'(lsu_rready), 1);
        chk("rst empty", 64'(buf_empty), 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-rst no write", 64'(rf_we), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
